// File: rtl/instruction_fetch_unit_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : instruction_fetch_unit_pkg
// Brief    : Shared widths, program size and fetch-word type for the IFU.
// Revision : 1.0
// ============================================================================
package instruction_fetch_unit_pkg;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 32;
   localparam int PC_LIMIT = 5;
   localparam int RESET_PC = 0;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fetch_word_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : instruction_fetch_unit_if
// Brief    : Memory request, redirect and decode-stream signals of the IFU.
// Revision : 1.0
// ============================================================================
interface instruction_fetch_unit_if;
   import instruction_fetch_unit_pkg::*;

   logic              fetch_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_instruction;
   logic              branch_valid;
   logic [ADDR_W-1:0] branch_target;
   logic              instr_ready;
   logic              instr_valid;
   logic [DATA_W-1:0] instr_out;
   logic [ADDR_W-1:0] pc_out;
   logic              fetch_err;

   modport master (
      input  fetch_en, mem_instruction, branch_valid, branch_target, instr_ready,
      output mem_addr, instr_valid, instr_out, pc_out, fetch_err
   );

   modport slave (
      output fetch_en, mem_instruction, branch_valid, branch_target, instr_ready,
      input  mem_addr, instr_valid, instr_out, pc_out, fetch_err
   );

endinterface
`default_nettype wire

// File: rtl/instruction_fetch_unit_skid.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : fetch_skid_buffer
// Brief    : Two-entry in-order out+skid register pair with push/pop/flush.
// Revision : 1.0
// ============================================================================
module fetch_skid_buffer
   import instruction_fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_push,
   input  fetch_word_t i_push_word,
   input  logic        i_pop,
   input  logic        i_flush,
   output logic        o_out_v,
   output fetch_word_t o_out_word,
   output logic [1:0]  o_count
);

   logic        r_out_v;
   logic        r_skid_v;
   fetch_word_t r_out_word;
   fetch_word_t r_skid_word;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_v     <= 1'b0;
         r_skid_v    <= 1'b0;
         r_out_word  <= '0;
         r_skid_word <= '0;
      end else if (i_flush) begin
         r_out_v  <= 1'b0;
         r_skid_v <= 1'b0;
      end else if (i_pop && r_out_v) begin
         // Skid always holds the older word, so it drains ahead of any push.
         if (r_skid_v) begin
            r_out_word <= r_skid_word;
            if (i_push) begin
               r_skid_word <= i_push_word;
            end else begin
               r_skid_v <= 1'b0;
            end
         end else if (i_push) begin
            r_out_word <= i_push_word;
         end else begin
            r_out_v <= 1'b0;
         end
      end else if (i_push) begin
         if (!r_out_v) begin
            r_out_v    <= 1'b1;
            r_out_word <= i_push_word;
         end else begin
            r_skid_v    <= 1'b1;
            r_skid_word <= i_push_word;
         end
      end
   end

   assign o_out_v    = r_out_v;
   assign o_out_word = r_out_word;
   assign o_count    = {1'b0, r_out_v} + {1'b0, r_skid_v};

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : PC, issue and redirect control feeding a decode valid/ready stream.
// Revision : 1.0
// ============================================================================
module instruction_fetch_unit
   import instruction_fetch_unit_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   instruction_fetch_unit_if.master bus
);

   localparam logic [ADDR_W-1:0] c_PC_LIMIT = ADDR_W'(PC_LIMIT);
   localparam logic [ADDR_W-1:0] c_PC_LAST  = ADDR_W'(PC_LIMIT - 1);
   localparam logic [ADDR_W-1:0] c_RESET_PC = ADDR_W'(RESET_PC);
   localparam logic [ADDR_W-1:0] c_PC_ONE   = ADDR_W'(1);

   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_inflight_pc;
   logic              r_inflight;
   logic              r_fetch_err;

   logic              w_pop;
   logic              w_issue;
   logic              w_bad_target;
   logic              w_push;
   logic              w_out_v;
   logic [1:0]        w_count;
   logic [2:0]        w_occ;
   fetch_word_t       w_push_word;
   fetch_word_t       w_out_word;

   assign w_pop        = w_out_v & bus.instr_ready;
   // Occupancy as it will stand after this edge's pop; keeps inflight+queued <= 2.
   assign w_occ        = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_issue      = bus.fetch_en & ~bus.branch_valid & (w_occ < 3'd2);
   assign w_bad_target = (bus.branch_target >= c_PC_LIMIT);
   assign w_push       = r_inflight & ~bus.branch_valid;

   assign w_push_word.pc    = r_inflight_pc;
   assign w_push_word.instr = bus.mem_instruction;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= c_RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_fetch_err   <= 1'b0;
      end else begin
         r_fetch_err <= bus.branch_valid & w_bad_target;
         if (bus.branch_valid) begin
            r_inflight <= 1'b0;
            r_pc       <= w_bad_target ? c_RESET_PC : bus.branch_target;
         end else if (w_issue) begin
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
            r_pc          <= (r_pc == c_PC_LAST) ? '0 : r_pc + c_PC_ONE;
         end else begin
            r_inflight <= 1'b0;
         end
      end
   end

   fetch_skid_buffer u_skid (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_push      (w_push),
      .i_push_word (w_push_word),
      .i_pop       (w_pop),
      .i_flush     (bus.branch_valid),
      .o_out_v     (w_out_v),
      .o_out_word  (w_out_word),
      .o_count     (w_count)
   );

   assign bus.mem_addr    = r_pc;
   assign bus.instr_valid = w_out_v;
   assign bus.instr_out   = w_out_word.instr;
   assign bus.pc_out      = w_out_word.pc;
   assign bus.fetch_err   = r_fetch_err;

endmodule
`default_nettype wire
